// File: rtl/lal_frame_tx.sv
// Serial frame transmitter: FIFO-buffered command words sent as start, LSB-first data,
// even parity and stop bits, each held for DIV clock cycles.
module lal_frame_tx #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DIV   = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx_line,
    output logic                   tx_busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] Full    = CW'(DEPTH);
    localparam logic [7:0]    BitLast = 8'(DIV - 1);
    localparam logic [IW-1:0] IdxLast = IW'(WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t            state_q;
    logic [7:0]        bit_cnt_q;
    logic [IW-1:0]     idx_q;
    logic [WIDTH-1:0]  shift_q;
    logic              parity_q;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic              push;
    logic              pop;
    logic              bit_end;
    logic              fifo_nonempty;
    logic [WIDTH-1:0]  head;

    // Readiness comes from the registered count only, so a pop never frees a slot same-cycle.
    assign in_ready      = (count_q < Full) && !reset;
    assign push          = in_valid && in_ready;
    assign bit_end       = (bit_cnt_q == BitLast);
    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty &&
                           ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    assign head          = mem_q[rd_ptr_q];
    assign fifo_count    = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_line   <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            if ((state_q == StIdle) || bit_end) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 8'd1;
            end

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q  <= head;
                        parity_q <= ^head;
                        state_q  <= StStart;
                        tx_line  <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        idx_q   <= '0;
                        tx_line <= shift_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (idx_q == IdxLast) begin
                            state_q <= StParity;
                            tx_line <= parity_q;
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + IW'(1);
                            tx_line <= shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop;
                        tx_line <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        // Chain straight into the next start bit when more words are queued.
                        if (pop) begin
                            shift_q  <= head;
                            parity_q <= ^head;
                            state_q  <= StStart;
                            tx_line  <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_line <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lal_frame_tx.sv
// Directed bench for lal_frame_tx: a default instance (DIV=4) and a DIV=1 instance,
// with line/busy captured every cycle and compared against a frame model.
`timescale 1ns/1ps
module tb_lal_frame_tx;
    logic        clock = 1'b0;
    logic        reset;
    logic [25:0] in_data, in_data1;
    logic        in_valid, in_valid1;
    logic        in_ready, tx_line, tx_busy, overflow;
    logic        in_ready1, tx_line1, tx_busy1, overflow1;
    logic [2:0]  fifo_count, fifo_count1;

    int checks = 0;
    int failures = 0;

    bit   cap_en = 1'b0;
    logic cap0_line[$];
    logic cap0_busy[$];
    logic cap1_line[$];
    logic cap1_busy[$];
    logic [25:0] exp_words[$];

    lal_frame_tx #(.WIDTH(26), .DIV(4), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_line(tx_line), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    lal_frame_tx #(.WIDTH(26), .DIV(1), .DEPTH(4)) dut1 (
        .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx_line(tx_line1), .tx_busy(tx_busy1),
        .fifo_count(fifo_count1), .overflow(overflow1)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cap_en) begin
            cap0_line.push_back(tx_line);
            cap0_busy.push_back(tx_busy);
            cap1_line.push_back(tx_line1);
            cap1_busy.push_back(tx_busy1);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_capture();
        cap0_line.delete();
        cap0_busy.delete();
        cap1_line.delete();
        cap1_busy.delete();
    endtask

    task automatic wait_idle(input int sel, input int bound, input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < bound) begin
            tick();
            n++;
            if (sel == 0) done = (tx_busy === 1'b0) && (fifo_count === 3'd0);
            else          done = (tx_busy1 === 1'b0) && (fifo_count1 === 3'd0);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, bound);
        end
        repeat (4) tick();
    endtask

    // Compares the captured waveform with exp_words sent back-to-back, then recovers each
    // word by mid-bit sampling. Returns the index of the first start-bit sample.
    task automatic check_stream(input int sel, input int div, input string name, output int s);
        logic ln[$];
        logic bz[$];
        int len, bad, first_bad, nbusy, idx;
        logic eb;
        logic [25:0] w, rx;
        if (sel == 0) begin ln = cap0_line; bz = cap0_busy; end
        else          begin ln = cap1_line; bz = cap1_busy; end
        s = -1;
        for (int i = 0; i < ln.size(); i++) begin
            if (s < 0 && ln[i] === 1'b0) s = i;
        end
        len = exp_words.size() * 29 * div;
        bad = 0;
        first_bad = -1;
        nbusy = 0;
        for (int i = 0; i < bz.size(); i++) if (bz[i] === 1'b1) nbusy++;
        checks++;
        if (s < 0) begin
            failures++;
            $display("FAIL %s_start: no start bit seen, required one", name);
            return;
        end
        for (int i = 0; i < ln.size(); i++) begin
            if (i < s || i >= s + len) begin
                if (ln[i] !== 1'b1 || bz[i] !== 1'b0) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
        end
        for (int f = 0; f < exp_words.size(); f++) begin
            w = exp_words[f];
            for (int b = 0; b < 29; b++) begin
                if (b == 0)       eb = 1'b0;
                else if (b <= 26) eb = w[b-1];
                else if (b == 27) eb = ^w;
                else              eb = 1'b1;
                for (int d = 0; d < div; d++) begin
                    idx = s + (f * 29 + b) * div + d;
                    if (idx >= ln.size() || ln[idx] !== eb || bz[idx] !== 1'b1) begin
                        bad++;
                        if (first_bad < 0) first_bad = idx;
                    end
                end
            end
        end
        if (s + len >= ln.size()) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_wave: %0d bad cycles (first at sample %0d), required 0",
                     name, bad, first_bad);
        end
        checks++;
        if (nbusy !== len) begin
            failures++;
            $display("FAIL %s_len: busy for %0d cycles, required %0d", name, nbusy, len);
        end
        for (int f = 0; f < exp_words.size(); f++) begin
            rx = '0;
            for (int k = 0; k < 26; k++) begin
                idx = s + (f * 29 + 1 + k) * div + div / 2;
                if (idx < ln.size()) rx[k] = ln[idx];
            end
            checks++;
            if (rx !== exp_words[f]) begin
                failures++;
                $display("FAIL %s_rx%0d: received %h, required %h", name, f, rx, exp_words[f]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        in_data = '0;
        in_data1 = '0;
        repeat (3) tick();
        checks++;
        if ({tx_line, tx_busy, fifo_count, overflow} !== 6'b1_0_000_0) begin
            failures++;
            $display("FAIL reset_state: line=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                     tx_line, tx_busy, fifo_count, overflow);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b during reset, required 0", in_ready);
        end
        checks++;
        if ({tx_line1, tx_busy1, fifo_count1, overflow1} !== 6'b1_0_000_0) begin
            failures++;
            $display("FAIL reset_state_div1: line=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                     tx_line1, tx_busy1, fifo_count1, overflow1);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: in_ready=%b after reset, required 1", in_ready);
        end
        repeat (3) tick();
        checks++;
        if (tx_line !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: line=%b busy=%b, required 1 0", tx_line, tx_busy);
        end
    endtask

    task automatic test_single();
        int s;
        clear_capture();
        cap_en = 1'b1;
        exp_words = {26'h0000001};
        in_valid = 1'b1;
        in_data = 26'h0000001;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1 || tx_line !== 1'b1 || tx_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: count=%0d line=%b busy=%b, required 1 1 0",
                     fifo_count, tx_line, tx_busy);
        end
        tick();
        checks++;
        if (tx_line !== 1'b0 || tx_busy !== 1'b1 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL single_start: line=%b busy=%b count=%0d, required 0 1 0",
                     tx_line, tx_busy, fifo_count);
        end
        wait_idle(0, 300, "single");
        cap_en = 1'b0;
        check_stream(0, 4, "single", s);
        if (s >= 0 && s + 27 * 4 + 2 < cap0_line.size()) begin
            checks++;
            if (cap0_line[s + 27 * 4 + 2] !== 1'b1) begin
                failures++;
                $display("FAIL single_parity: parity=%b, required 1", cap0_line[s + 27 * 4 + 2]);
            end
        end
    endtask

    task automatic test_all_ones();
        int s;
        clear_capture();
        cap_en = 1'b1;
        exp_words = {26'h3FFFFFF};
        in_valid = 1'b1;
        in_data = 26'h3FFFFFF;
        tick();
        in_valid = 1'b0;
        wait_idle(0, 300, "ones");
        cap_en = 1'b0;
        check_stream(0, 4, "ones", s);
        if (s >= 0 && s + 27 * 4 + 2 < cap0_line.size()) begin
            checks++;
            if (cap0_line[s + 27 * 4 + 2] !== 1'b0) begin
                failures++;
                $display("FAIL ones_parity: parity=%b, required 0", cap0_line[s + 27 * 4 + 2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        clear_capture();
        cap_en = 1'b1;
        exp_words = {26'h0000001, 26'h0000002, 26'h0000003, 26'h0000004, 26'h0000005};
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data = 26'(i);
            tick();
        end
        checks++;
        if (fifo_count !== 3'd4 || in_ready !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: count=%0d ready=%b ovf=%b, required 4 0 0",
                     fifo_count, in_ready, overflow);
        end
        in_data = 26'h0000006;
        tick();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL fill_overflow: ovf=%b count=%0d, required 1 4", overflow, fifo_count);
        end
        wait_idle(0, 800, "b2b");
        cap_en = 1'b0;
        check_stream(0, 4, "b2b", s);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%b, required 1", overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        in_valid = 1'b1;
        in_data = 26'h0000155;
        tick();
        in_data = 26'h00000AA;
        tick();
        in_data = 26'h0000033;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd2) begin
            failures++;
            $display("FAIL mid_queued: count=%0d, required 2", fifo_count);
        end
        repeat (44) tick();
        checks++;
        if (tx_line !== 1'b0 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_bit10: line=%b busy=%b, required 0 1", tx_line, tx_busy);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tx_line !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: line=%b count=%0d busy=%b ovf=%b, required 1 0 0 0",
                     tx_line, fifo_count, tx_busy, overflow);
        end
        reset = 1'b0;
        clear_capture();
        cap_en = 1'b1;
        repeat (150) tick();
        cap_en = 1'b0;
        for (int i = 0; i < cap0_line.size(); i++) begin
            if (cap0_line[i] !== 1'b1 || cap0_busy[i] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || cap0_line.size() == 0) begin
            failures++;
            $display("FAIL mid_silent: %0d active cycles of %0d after reset, required 0",
                     bad, cap0_line.size());
        end
    endtask

    task automatic test_div1();
        int s;
        clear_capture();
        cap_en = 1'b1;
        exp_words = {26'h2AAAAAA};
        in_valid1 = 1'b1;
        in_data1 = 26'h2AAAAAA;
        tick();
        in_valid1 = 1'b0;
        wait_idle(1, 100, "div1");
        cap_en = 1'b0;
        check_stream(1, 1, "div1", s);
        if (s >= 0 && s + 27 < cap1_line.size()) begin
            checks++;
            if (cap1_line[s + 1] !== 1'b0 || cap1_line[s + 2] !== 1'b1
                || cap1_line[s + 27] !== 1'b1) begin
                failures++;
                $display("FAIL div1_bits: bit0=%b bit1=%b parity=%b, required 0 1 1",
                         cap1_line[s + 1], cap1_line[s + 2], cap1_line[s + 27]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_ones();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lal_frame_tx.md
# lal_frame_tx

Serial frame transmitter for the 26-bit command word consumed by the lal decode logic. The transmitter buffers parallel command words from a valid/ready source in a small FIFO and serialises each word onto a single line. Each frame is a start bit, the data LSB first, an even-parity bit and a stop bit. It sits between the command generator and the serial link into the decoder-side receiver.

## Interface
- WIDTH, 26: data bits per frame.
- DIV, 4: clock cycles per bit period; legal range 1..255.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.

- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_data  input  WIDTH  command word to queue.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word; equals (count < DEPTH) and not reset.
- tx_line  output  1  serial line; idles high; registered.
- tx_busy  output  1  high while a frame is in START/DATA/PARITY/STOP; registered.
- fifo_count  output  $clog2(DEPTH)+1  number of queued words, excluding the word in flight.
- overflow  output  1  sticky flag; set when in_valid=1 while in_ready=0; cleared only by reset.

## Operation
- Push: when in_valid and in_ready are both high at a rising edge, the word is written at the tail and count increments.
- in_ready depends only on the registered count. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- States and transitions:
  - IDLE: if count>0, pop the head into the shift register, compute even parity (XOR of all data bits), and go to START. Otherwise stay in IDLE.
  - START: tx_line=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_line=shift[0] for DIV cycles. Then shift right and increment the index. After bit WIDTH-1, go to PARITY.
  - PARITY: tx_line=parity for DIV cycles, then go to STOP.
  - STOP: tx_line=1 for DIV cycles. At the end of STOP:
    - if count>0, pop and go directly to START, with no idle gap;
    - otherwise go to IDLE.
- A push and a pop in the same cycle leave count unchanged; the pointers wrap modulo DEPTH.
- The bit-period counter counts 0..DIV-1, and the state advances when it reaches DIV-1. With DIV=1 every bit lasts exactly one cycle.
- overflow sets on the edge where in_valid=1 and in_ready=0. A refused word is dropped and is never transmitted.

## Timing
- Reset values: tx_line=1, tx_busy=0, fifo_count=0, overflow=0, state IDLE. in_ready is 0 while reset is high and 1 in the first cycle after.
- Reset mid-frame: on the reset edge tx_line returns to 1, the FIFO and the in-flight word are discarded, and no stop bit is emitted.
- Latency: word accepted at edge N into an empty, idle block → pop at edge N+1 → tx_line=0 and tx_busy=1 from edge N+1.
- Frame length is (WIDTH+3)*DIV cycles, which is 116 cycles at the defaults.
- Data bit k occupies cycles N+1+(k+1)*DIV .. N+(k+2)*DIV after acceptance.
- Back-to-back frames: the start bit of the next frame follows the last stop-bit cycle directly, and tx_busy stays 1 across the boundary.
- tx_busy falls on the edge after the final STOP cycle, and only when the FIFO is empty.

## Test plan
- Reset then idle:
  - hold reset 3 cycles with in_valid=0 → tx_line=1, tx_busy=0, fifo_count=0, overflow=0;
  - in_ready=0 during reset and 1 in the first cycle after.
- Single frame, defaults, in_data=26'h0000001:
  - tx_line low for 4 cycles starting one cycle after acceptance, then data bit0=1 for 4 cycles, then 25 zero bits, then parity=1, then stop=1;
  - total 116 cycles, after which tx_busy=0.
- All ones, in_data=26'h3FFFFFF: parity bit is 0. Bench receiver model recovers 26'h3FFFFFF.
- Fill and overflow:
  - push 26'h0000001, 26'h0000002, 26'h0000003, 26'h0000004, 26'h0000005 on consecutive cycles with DEPTH=4 → first word pops immediately, the rest fill the FIFO (fifo_count=4);
  - a sixth push while full is refused, overflow=1, and that word is never transmitted;
  - five frames go out back-to-back with no idle cycle between them.
- Reset mid-frame: assert reset during data bit 10 of a frame with 2 words queued → tx_line=1 on the next edge, fifo_count=0, and nothing is transmitted afterwards.
- DIV=1, in_data=26'h2AAAAAA: 29-cycle frame, data bits alternate 0/1 starting with bit0=0, parity=1.
